// File: rtl/seq_mult32_if.sv
// seq_mult32_if -- request/result bundle for the 32x32 sequential multiplier.
//
// Signals (named from the multiplier's point of view):
//   i_start   request a multiply (sampled on the rising edge)
//   i_signed  1 = two's-complement operands, 0 = unsigned (sampled with i_start)
//   i_a       32-bit multiplicand (sampled with i_start)
//   i_b       32-bit multiplier   (sampled with i_start)
//   o_busy    high while an accepted operation is iterating
//   o_done    one-cycle pulse; o_hi/o_lo are valid from this cycle onward
//   o_hi      product bits [63:32]
//   o_lo      product bits [31:0]
//
// Modports: master = requester, slave = multiplier.
interface seq_mult32_if;
  logic        i_start;
  logic        i_signed;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  modport master (
    output i_start, i_signed, i_a, i_b,
    input  o_busy, o_done, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_signed, i_a, i_b,
    output o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/seq_mult32.sv
// seq_mult32 -- 32x32 -> 64-bit sequential multiplier, radix-2 shift-add.
//
// Ports:
//   i_clk  single clock, all state changes on the rising edge
//   i_rst  synchronous active-high reset
//   bus    seq_mult32_if.slave (start/signed/a/b in, busy/done/hi/lo out)
//
// Operation: a start in IDLE or FIN captures the operands (as magnitudes
// when signed) and enters RUN. RUN consumes one multiplier bit per edge,
// LSB first, for exactly 32 edges, then enters FIN and loads {hi,lo} with
// the (optionally negated) product. FIN lasts one cycle unless a new start
// arrives, which begins the next operation back-to-back.
module seq_mult32 (
  input  logic          i_clk,
  input  logic          i_rst,
  seq_mult32_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [63:0] r_mcand;    // multiplicand magnitude, shifted left each edge
  logic [31:0] r_mplier;   // multiplier magnitude, shifted right each edge
  logic [63:0] r_acc;      // partial-product accumulator
  logic [5:0]  r_cnt;      // RUN edges already taken
  logic        r_neg;      // result must be negated at the end
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_busy;
  logic        w_done;
  logic        w_last;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_acc_sum;
  logic [63:0] w_product;

  // Negating 0x80000000 in 32 bits gives 0x80000000, which is exactly the
  // magnitude needed when it is read as unsigned.
  assign w_mag_a = (bus.i_signed && bus.i_a[31]) ? (~bus.i_a + 32'd1) : bus.i_a;
  assign w_mag_b = (bus.i_signed && bus.i_b[31]) ? (~bus.i_b + 32'd1) : bus.i_b;

  // Accumulator value after the current RUN edge; on the final edge this is
  // the full unsigned magnitude product.
  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
  assign w_product = r_neg ? (~w_acc_sum + 64'd1) : w_acc_sum;
  assign w_last    = (r_cnt == 6'd31);

  // Next-state and decoded outputs.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        w_done = 1'b1;
        if (bus.i_start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath. Accept only happens in IDLE/FIN, so it never collides with
  // the RUN iteration branch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_acc    <= 64'd0;
      r_cnt    <= 6'd0;
      r_neg    <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else if (w_accept) begin
      r_mcand  <= {32'd0, w_mag_a};
      r_mplier <= w_mag_b;
      r_acc    <= 64'd0;
      r_cnt    <= 6'd0;
      r_neg    <= bus.i_signed & (bus.i_a[31] ^ bus.i_b[31]);
    end else if (r_state == ST_RUN) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= {r_mcand[62:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[31:1]};
      r_cnt    <= r_cnt + 6'd1;
      if (w_last) begin
        r_hi <= w_product[63:32];
        r_lo <= w_product[31:0];
      end
    end
  end

  assign bus.o_busy = w_busy;
  assign bus.o_done = w_done;
  assign bus.o_hi   = r_hi;
  assign bus.o_lo   = r_lo;

endmodule

// File: tb/tb_seq_mult32.sv
// tb_seq_mult32 -- self-checking bench for seq_mult32.
// Drives directed and $urandom operands, compares against a plain-arithmetic
// 64-bit product, and checks BUSY length, DONE timing, result stability,
// back-to-back starts and mid-operation reset.
module tb_seq_mult32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  seq_mult32_if mif ();

  seq_mult32 dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: full-width product using sign/zero extension and native multiply.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] xa;
    logic [63:0] xb;
    xa = s ? {{32{a[31]}}, a} : {32'd0, a};
    xb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return xa * xb;
  endfunction

  // Present a request at a falling edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    mif.i_start  = 1'b1;
    mif.i_a      = a;
    mif.i_b      = b;
    mif.i_signed = s;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the accepting edge. Scrambles the operand inputs every
  // cycle (and keeps START high when hold=1) and returns in the DONE cycle.
  task automatic wait_result(input logic [63:0] exp, input bit hold, input string tag);
    int          busy_n;
    int          done_n;
    bit          stable;
    bit          overlap;
    logic [63:0] hl0;
    busy_n  = 0;
    done_n  = 0;
    stable  = 1'b1;
    overlap = 1'b0;
    hl0     = {mif.o_hi, mif.o_lo};
    for (int i = 0; i < 40; i++) begin
      if (mif.o_busy && mif.o_done) overlap = 1'b1;
      if (mif.o_done) begin
        done_n++;
        break;
      end
      if (mif.o_busy) busy_n++;
      if ({mif.o_hi, mif.o_lo} !== hl0) stable = 1'b0;
      @(negedge clk);
      mif.i_start  = hold;
      mif.i_a      = $urandom;
      mif.i_b      = $urandom;
      mif.i_signed = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk({tag, " done"}, 64'(done_n), 64'd1);
    chk({tag, " busy_cycles"}, 64'(busy_n), 64'd32);
    chk({tag, " hilo_stable_in_run"}, 64'(stable), 64'd1);
    chk({tag, " busy_done_overlap"}, 64'(overlap), 64'd0);
    chk({tag, " product"}, {mif.o_hi, mif.o_lo}, exp);
    $display("op %s: {hi,lo}=0x%h expected 0x%h", tag, {mif.o_hi, mif.o_lo}, exp);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit hold, input string tag);
    start_op(a, b, s);
    wait_result(ref_mul(a, b, s), hold, tag);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    bit          hold;
    int          dn;

    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    mif.i_start  = 1'b1;   // must be ignored while reset is high
    mif.i_signed = 1'b0;
    mif.i_a      = 32'd7;
    mif.i_b      = 32'd9;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(mif.o_busy), 64'd0);
    chk("reset done", 64'(mif.o_done), 64'd0);
    chk("reset hilo", {mif.o_hi, mif.o_lo}, 64'd0);

    // First START accepted on the first edge with reset low.
    @(negedge clk);
    rst          = 1'b0;
    mif.i_start  = 1'b1;
    mif.i_a      = 32'd3;
    mif.i_b      = 32'd5;
    mif.i_signed = 1'b0;
    @(posedge clk);
    #1;
    chk("first_start busy", 64'(mif.o_busy), 64'd1);
    wait_result(64'h0000_0000_0000_000F, 1'b0, "u3x5");

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "u_max_x_max");
    run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, "s_m1_x_2");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "s_min_x_min");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, "s_min_x_1");
    run_op(32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0, "zero_a");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "u_min_x_min");

    // START held high with changing operands, then START in the FIN cycle.
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, "hold_first");
    run_op(32'hDEAD_BEEF, 32'h0000_0003, 1'b1, 1'b0, "back_to_back");

    for (int i = 0; i < 20; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rs   = 1'($urandom_range(0, 1));
      hold = bit'($urandom_range(0, 1));
      run_op(ra, rb, rs, hold, $sformatf("rand%0d", i));
    end

    // Reset after the 10th RUN edge aborts the operation.
    start_op(32'h0000_1111, 32'h0000_2222, 1'b0);
    mif.i_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy", 64'(mif.o_busy), 64'd0);
    chk("abort done", 64'(mif.o_done), 64'd0);
    chk("abort hilo", {mif.o_hi, mif.o_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dn  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (mif.o_done) dn++;
    end
    chk("abort no_done_40", 64'(dn), 64'd0);

    // Normal operation resumes after the abort.
    run_op(32'hFFFF_FFF9, 32'h0000_0007, 1'b1, 1'b0, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench cannot hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected completion before 500000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_mult32.md
SEQ_MULT32 -- requirements
Module: seq_mult32

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits and product width at 64 bits.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request a multiply; sampled on the rising edge.
REQ-005 SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START.
REQ-006 A  input  32  multiplicand; sampled with START.
REQ-007 B  input  32  multiplier; sampled with START.
REQ-008 BUSY  output  1  high while an accepted operation is iterating.
REQ-009 DONE  output  1  one-cycle pulse; HI/LO are valid from this cycle onward.
REQ-010 HI  output  32  product bits [63:32]; drives a 32-bit input of the result-select mux.
REQ-011 LO  output  32  product bits [31:0]; drives a 32-bit input of the result-select mux.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, FIN.
REQ-013 In IDLE or FIN, START=1 at an edge SHALL capture A, B and SIGNED, and SHALL enter RUN.
REQ-014 In RUN, START SHALL be ignored.
- Operand changes after capture SHALL NOT affect the result.
REQ-015 Captured operands SHALL be converted to magnitudes when SIGNED=1.
- Magnitude of 0x80000000 is 0x80000000 as unsigned.
- A result-negate flag SHALL equal sign(A) XOR sign(B).
REQ-016 RUN SHALL perform radix-2 shift-add, one multiplier bit per edge, LSB first, for exactly 32 edges.
- A 6-bit iteration counter controls the iterations.
- Accumulator is 64-bit; no carry is lost.
REQ-017 On the 32nd RUN edge, the FSM SHALL enter FIN and SHALL load {HI,LO} with the product.
- The product is 64-bit two's-complement negated when the negate flag is set.
REQ-018 Latency: START accepted at edge k SHALL give BUSY=1 for the cycles after edges k..k+31, and DONE=1 for the single cycle after edge k+32.
REQ-019 FIN SHALL return to IDLE on the next edge unless START=1, which SHALL start a new operation back-to-back.
REQ-020 DONE SHALL be high only in FIN; BUSY SHALL be high only in RUN; both SHALL never be high together.
REQ-021 HI/LO SHALL hold their last result until the next FIN entry.
- HI/LO SHALL NOT change during RUN.
REQ-022 Zero operands SHALL still take the full 32 iterations.
- There is no early termination.

Reset
REQ-023 RST=1 at an edge SHALL force IDLE, BUSY=0, DONE=0, HI=0, LO=0, and SHALL clear the counter and accumulator.
REQ-024 RST SHALL take priority over START and over any RUN/FIN activity.
- Reset mid-operation SHALL abort the operation with no DONE pulse.
REQ-025 The first START SHALL be accepted on the first edge with RST=0.

Verification
REQ-026 Unsigned 3 x 5, START at edge k -> DONE pulse after edge k+32, HI=0x00000000, LO=0x0000000F, BUSY high exactly 32 cycles.
REQ-027 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; signed 0xFFFFFFFF x 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-028 Signed 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000; signed 0x80000000 x 0x00000001 -> HI=0xFFFFFFFF, LO=0x80000000.
REQ-029 START held high and A/B changed every cycle during RUN -> exactly one DONE; result equals the first captured operands; START in the FIN cycle -> second operation with BUSY in the next cycle.
REQ-030 RST asserted after the 10th RUN edge -> next cycle BUSY=0, DONE=0, HI=LO=0; no DONE within the following 40 cycles without a new START.
